spi_bus_arbiter: RTL and testbench

Shares one single-byte SPI transaction engine among NUM_REQ requesters, e.g. the IMU config writer, the periodic IMU reader and a future second sensor.
- Grants round-robin and launches the engine with a one-cycle enable pulse.
- Returns read data and a per-requester done pulse.
- Enforces an idle gap between transactions (CS-high time) and a watchdog timeout.
- Sits between the sensor controllers and the spi engine; the only owner of the engine's enable/addr/wdata/read inputs.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_bus_arbiter_rr_picker.sv | 33 +++
 rtl/spi_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and sensor register addresses for the SPI bus arbiter and its clients.
package spi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAUNCH = 2'd1,
    ARB_BUSY   = 2'd2,
    ARB_GAP    = 2'd3
  } arb_state_t;

  localparam logic [7:0] CTRL9_XL = 8'h18;
  localparam logic [7:0] CTRL4_C  = 8'h13;
  localparam logic [7:0] CTRL2_G  = 8'h11;
  localparam logic [7:0] CTRL1_XL = 8'h10;
  localparam logic [7:0] OUTX_L_G = 8'h22;

endpackage

// File: rtl/spi_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module rr_picker #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] index
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(N);

  logic [N-1:0]     rot_s;
  logic [PTR_W-1:0] off_s;
  logic [PTR_W:0]   sum_s;

  // rot_s[k] is requester (ptr + k) mod N
  assign rot_s = N'({req, req} >> ptr);

  // Lowest set offset in the rotated vector
  always_comb begin
    off_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? PTR_W'(k) : off_s;
    end
  end

  assign sum_s = {1'b0, ptr} + {1'b0, off_s};
  assign found = |req;
  assign index = (sum_s >= N_EXT) ? PTR_W'(sum_s - N_EXT) : PTR_W'(sum_s);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of a single-byte SPI engine: grants, launches, enforces CS-high gap
// and a BUSY watchdog, and returns per-requester completion with read data.
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_addr,
  input  logic [NUM_REQ*8-1:0]       req_wdata,
  input  logic [NUM_REQ-1:0]         req_read,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [7:0]                 rsp_rdata,
  output logic                       rsp_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       eng_enable,
  output logic [7:0]                 eng_addr,
  output logic [7:0]                 eng_wdata,
  output logic                       eng_read,
  input  logic [7:0]                 eng_rdata,
  input  logic                       eng_done
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] DONE_LSB = NUM_REQ'(1'b1);

  arb_state_t          state_r, next_state_s;
  logic [ID_W-1:0]     rr_ptr_r, next_ptr_s, pick_index_s, grant_id_r;
  logic                pick_found_s, grant_s, finish_s, to_expire_s, gap_last_s;
  logic [TO_W-1:0]     to_cnt_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic [NUM_REQ-1:0]  req_done_r;
  logic [7:0]          rsp_rdata_r, eng_addr_r, eng_wdata_r;
  logic                rsp_err_r, busy_r, eng_enable_r, eng_read_r;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .index (pick_index_s)
  );

  assign to_expire_s = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
  assign gap_last_s  = (gap_cnt_r == GAP_W'(GAP_CYCLES - 1));
  assign next_ptr_s  = (grant_id_r == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_r + ID_W'(1'b1);

  // Next-state and transition strobes
  always_comb begin
    next_state_s = state_r;
    grant_s      = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (pick_found_s) begin
          grant_s      = 1'b1;
          next_state_s = ARB_LAUNCH;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      ARB_LAUNCH: next_state_s = ARB_BUSY;
      ARB_BUSY: begin
        // eng_done wins over a same-cycle timeout
        if (eng_done || to_expire_s) begin
          finish_s     = 1'b1;
          next_state_s = ARB_GAP;
        end else begin
          next_state_s = ARB_BUSY;
        end
      end
      ARB_GAP: begin
        if (gap_last_s) begin
          next_state_s = ARB_IDLE;
        end else begin
          next_state_s = ARB_GAP;
        end
      end
      default: next_state_s = ARB_IDLE;
    endcase
  end

  // State register and registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ARB_IDLE;
      eng_enable_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      eng_enable_r <= (state_r == ARB_LAUNCH);
      busy_r       <= (next_state_s != ARB_IDLE);
    end
  end

  // Grant capture, payload latch and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id_r  <= '0;
      rr_ptr_r    <= '0;
      eng_addr_r  <= 8'h00;
      eng_wdata_r <= 8'h00;
      eng_read_r  <= 1'b0;
    end else begin
      if (grant_s) begin
        grant_id_r  <= pick_index_s;
        eng_addr_r  <= req_addr[{pick_index_s, 3'b000} +: 8];
        eng_wdata_r <= req_wdata[{pick_index_s, 3'b000} +: 8];
        eng_read_r  <= req_read[pick_index_s];
      end
      if (finish_s) begin
        rr_ptr_r <= next_ptr_s;
      end
    end
  end

  // Watchdog and gap counters
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r  <= '0;
      gap_cnt_r <= '0;
    end else begin
      if (state_r == ARB_LAUNCH) begin
        to_cnt_r <= '0;
      end else if (state_r == ARB_BUSY) begin
        to_cnt_r <= to_cnt_r + TO_W'(1'b1);
      end
      if (finish_s) begin
        gap_cnt_r <= '0;
      end else if (state_r == ARB_GAP) begin
        gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
      end
    end
  end

  // Completion response; rsp_rdata only moves on a successful read
  always_ff @(posedge clk) begin
    if (reset) begin
      req_done_r  <= '0;
      rsp_rdata_r <= 8'h00;
      rsp_err_r   <= 1'b0;
    end else begin
      req_done_r <= finish_s ? (DONE_LSB << grant_id_r) : '0;
      if (finish_s) begin
        rsp_err_r <= ~eng_done;
        if (eng_done && eng_read_r) begin
          rsp_rdata_r <= eng_rdata;
        end
      end
    end
  end

  assign req_done   = req_done_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign rsp_err    = rsp_err_r;
  assign grant_id   = grant_id_r;
  assign busy       = busy_r;
  assign eng_enable = eng_enable_r;
  assign eng_addr   = eng_addr_r;
  assign eng_wdata  = eng_wdata_r;
  assign eng_read   = eng_read_r;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized self-checking bench for spi_bus_arbiter against a transaction-level model.
module tb_spi_bus_arbiter;
  import spi_pkg::*;

  localparam int N  = 3;
  localparam int G  = 8;
  localparam int TO = 4096;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*8-1:0]   req_addr;
  logic [N*8-1:0]   req_wdata;
  logic [N-1:0]     req_read;
  logic [N-1:0]     req_done;
  logic [7:0]       rsp_rdata;
  logic             rsp_err;
  logic [1:0]       grant_id;
  logic             busy;
  logic             eng_enable;
  logic [7:0]       eng_addr;
  logic [7:0]       eng_wdata;
  logic             eng_read;
  logic [7:0]       eng_rdata;
  logic             eng_done;

  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;
  logic [7:0] last_rdata_m = 8'h00;

  spi_bus_arbiter #(
    .NUM_REQ        (N),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_read   (req_read),
    .req_done   (req_done),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .grant_id   (grant_id),
    .busy       (busy),
    .eng_enable (eng_enable),
    .eng_addr   (eng_addr),
    .eng_wdata  (eng_wdata),
    .eng_read   (eng_read),
    .eng_rdata  (eng_rdata),
    .eng_done   (eng_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Round-robin rule: first requesting index at or after p, wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic load(input int i, input logic [7:0] a, input logic [7:0] w, input logic r);
    req_addr[8*i +: 8]  = a;
    req_wdata[8*i +: 8] = w;
    req_read[i]         = r;
  endtask

  task automatic load_random(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) load(i, 8'($urandom), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic wait_enable(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (eng_enable !== 1'b1 && lat < 64);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    eng_done  = 1'b0;
    step();
    step();
    reset        = 1'b0;
    ptr_m        = 0;
    last_rdata_m = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_done"},  32'(req_done), 32'd0);
    check_eq({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check_eq({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
    check_eq({tag, "_busy"},      32'(busy), 32'd0);
    check_eq({tag, "_enable"},    32'(eng_enable), 32'd0);
    check_eq({tag, "_eng_addr"},  32'(eng_addr), 32'd0);
    check_eq({tag, "_eng_wdata"}, 32'(eng_wdata), 32'd0);
    check_eq({tag, "_eng_read"},  32'(eng_read), 32'd0);
    check_eq({tag, "_grant_id"},  32'(grant_id), 32'd0);
  endtask

  // Starts at the eng_enable sample; ends at the req_done sample.
  task automatic serve(input int idx, input int d, input logic [7:0] data, input bit tmo, input bit keep);
    logic [7:0] ea, ew;
    logic       er, extra, en_extra;
    int         cnt;
    ea = req_addr[8*idx +: 8];
    ew = req_wdata[8*idx +: 8];
    er = req_read[idx];
    check_eq("grant_id", 32'(grant_id), 32'(idx));
    check_eq("eng_addr", 32'(eng_addr), 32'(ea));
    check_eq("eng_wdata", 32'(eng_wdata), 32'(ew));
    check_eq("eng_read", 32'(eng_read), 32'(er));
    check_eq("busy_in_txn", 32'(busy), 32'd1);
    req_addr[8*idx +: 8]  = ~ea;
    req_wdata[8*idx +: 8] = ew ^ 8'h5A;
    if (!keep && $urandom_range(0, 1) == 1) req_valid[idx] = 1'b0;
    extra    = 1'b0;
    en_extra = 1'b0;
    cnt      = 0;
    if (tmo) begin
      while (req_done == '0 && cnt < TO + 16) begin
        step();
        cnt++;
        en_extra |= eng_enable;
      end
      check_eq("timeout_cycles", 32'(cnt), 32'(TO));
    end else begin
      for (int k = 0; k < d; k++) begin
        step();
        extra    |= |req_done;
        en_extra |= eng_enable;
      end
      eng_rdata = data;
      eng_done  = 1'b1;
      step();
      eng_done  = 1'b0;
      eng_rdata = 8'($urandom);
    end
    check_eq("early_done", 32'(extra), 32'd0);
    check_eq("enable_single_pulse", 32'(en_extra), 32'd0);
    check_eq("req_done", 32'(req_done), 32'd1 << idx);
    check_eq("rsp_err", 32'(rsp_err), 32'(tmo));
    if (er && !tmo) last_rdata_m = data;
    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata_m));
    check_eq("payload_latched", 32'(eng_addr), 32'(ea));
    ptr_m = (idx + 1) % N;
  endtask

  // Starts at the req_done sample; leaves the arbiter IDLE.
  task automatic gap_check(input bit stale);
    req_valid = '0;
    eng_done  = stale;
    step();
    eng_done  = 1'b0;
    check_eq("req_done_one_cycle", 32'(req_done), 32'd0);
    for (int k = 2; k < G; k++) step();
    check_eq("busy_in_gap", 32'(busy), 32'd1);
    step();
    check_eq("busy_after_gap", 32'(busy), 32'd0);
    eng_done = stale;
    step();
    eng_done = 1'b0;
    check_eq("stale_idle_done", 32'(req_done), 32'd0);
    check_eq("stale_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [N-1:0] vec;
    int idx, lat;
    logic extra;
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_read  = '0;
    eng_rdata = 8'h00;
    eng_done  = 1'b0;
    do_reset();
    check_all_zero("reset");

    // Single write from requester 1
    load(1, CTRL1_XL, 8'h50, 1'b0);
    vec = 3'b010;
    idx = model_pick(vec, ptr_m);
    req_valid = vec;
    wait_enable(lat);
    check_eq("latency_write", 32'(lat), 32'd2);
    serve(idx, 20, 8'h3C, 1'b0, 1'b1);
    gap_check(1'b0);

    // Single read from requester 0
    load(0, OUTX_L_G, 8'h00, 1'b1);
    vec = 3'b001;
    idx = model_pick(vec, ptr_m);
    req_valid = vec;
    wait_enable(lat);
    check_eq("latency_read", 32'(lat), 32'd2);
    serve(idx, 5, 8'hA5, 1'b0, 1'b1);
    gap_check(1'b1);

    // Engine never answers: watchdog abort
    vec = 3'b110;
    load_random(vec);
    idx = model_pick(vec, ptr_m);
    req_valid = vec;
    wait_enable(lat);
    check_eq("latency_timeout", 32'(lat), 32'd2);
    serve(idx, 0, 8'h00, 1'b1, 1'b1);
    gap_check(1'b0);

    // Reset in the middle of BUSY
    vec = N'($urandom_range(1, 7));
    load_random(vec);
    req_valid = vec;
    wait_enable(lat);
    check_eq("latency_pre_reset", 32'(lat), 32'd2);
    step();
    step();
    reset     = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
    check_all_zero("mid_reset");
    ptr_m        = 0;
    last_rdata_m = 8'h00;
    extra = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      extra |= (|req_done) | eng_enable | busy;
    end
    check_eq("quiet_after_reset", 32'(extra), 32'd0);
    vec = N'($urandom_range(1, 7));
    load_random(vec);
    idx = model_pick(vec, ptr_m);
    req_valid = vec;
    wait_enable(lat);
    check_eq("latency_post_reset", 32'(lat), 32'd2);
    serve(idx, 3, 8'($urandom), 1'b0, 1'b1);
    gap_check(1'b1);

    // Contention: everyone held high from a fresh reset
    do_reset();
    vec = 3'b111;
    load_random(vec);
    req_valid = vec;
    wait_enable(lat);
    check_eq("latency_contention", 32'(lat), 32'd2);
    for (int t = 0; t < 6; t++) begin
      idx = model_pick(vec, ptr_m);
      serve(idx, 4 + t, 8'($urandom), 1'b0, 1'b1);
      if (t < 5) begin
        wait_enable(lat);
        check_eq("enable_spacing", 32'(lat), 32'(G + 2));
      end
    end
    gap_check(1'b0);

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      vec = N'($urandom_range(1, 7));
      load_random(vec);
      idx = model_pick(vec, ptr_m);
      req_valid = vec;
      wait_enable(lat);
      check_eq("latency_rand", 32'(lat), 32'd2);
      serve(idx, $urandom_range(1, 30), 8'($urandom), 1'b0, 1'b0);
      gap_check(1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
